logic_microop_sequencer: RTL
============================

Name: logic_microop_sequencer

Overview:
- Initiator side of the logic-microoperation interface: a sequencer that holds a 4-entry operand register bank and accepts AND/OR/XOR/NOT commands over a valid/ready port.
- For each command it drives operands and selects (a, b, s0, s1) into the external combinational logic unit, waits a settle window, captures the unit's result f, writes it back to the bank and returns it on a response handshake.
- Sits between the control path and the per-bit logic unit.

Parameters:
- WIDTH, 4, operand/result width in bits (matches logic unit data width).
- SETTLE_CYCLES, 1, number of cycles operands/selects are held before f is sampled (range 1..15).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ld_valid  input  1  direct write into register bank this cycle.
- ld_addr  input  2  bank index for load.
- ld_data  input  WIDTH  load data.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  sequencer can accept command.
- cmd_op  input  2  {s0,s1}: 00 AND, 01 OR, 10 XOR, 11 NOT(a).
- cmd_srca  input  2  bank index of operand a.
- cmd_srcb  input  2  bank index of operand b (read but irrelevant for NOT).
- cmd_dst  input  2  bank index for result write-back.
- mop_a  output  WIDTH  operand a to logic unit.
- mop_b  output  WIDTH  operand b to logic unit.
- mop_s0  output  1  select bit s0 to logic unit.
- mop_s1  output  1  select bit s1 to logic unit.
- mop_f  input  WIDTH  result from logic unit (combinational from mop_*).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  captured result.
- rsp_dst  output  2  bank index written.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE, bank entries all 0, mop_a/mop_b/mop_s0/mop_s1 = 0, rsp_valid=0, rsp_data=0, rsp_dst=0, busy=0, settle counter=0. All pending work is discarded.
- cmd_ready = (state==IDLE), combinational. Reads 1 immediately after reset deasserts.
- FSM states:
  - IDLE: accept on the edge where cmd_valid & cmd_ready. Operands are read from the bank at that edge (pre-load value if ld_valid hits same index that cycle). Register op, srca/srcb values and dst. Go to ISSUE with counter=SETTLE_CYCLES-1.
  - ISSUE: mop_a/mop_b/mop_s0/mop_s1 are registered outputs, stable for exactly SETTLE_CYCLES cycles. Counter decrements each cycle. On the edge where counter==0, sample mop_f into rsp_data, write bank[dst]=mop_f, set rsp_dst=dst and rsp_valid=1, and go to RESP.
  - RESP: rsp_valid, rsp_data and rsp_dst are held stable. When rsp_ready=1, clear rsp_valid at that edge and go to IDLE. mop_* outputs return to 0 on leaving ISSUE.
- Latency with SETTLE_CYCLES=1 and command accepted at edge N:
  - mop_* valid during cycle N..N+1.
  - rsp_valid rises after edge N+1.
  - Earliest next accept is at edge N+3 (rsp_ready held high).
- mop_* are 0 in IDLE and RESP; non-zero only in ISSUE.
- Loads are accepted in every state; ld_valid has no ready.
- Load and write-back to the same index on the same edge: write-back wins. Different indices: both take effect.
- A load to a source index after accept does not change the in-flight operands.
- NOT: mop_b is still driven with bank[srcb]; result depends on a only.
- srca==srcb==dst is legal; the old value is used as the operand.
- Bitwise results are WIDTH bits; there is no carry or overflow.
- rst asserted mid-ISSUE or mid-RESP: immediate abort to IDLE. No bank write for the aborted command; the response is lost.

Test Plan (WIDTH=4, SETTLE_CYCLES=1, bench models logic unit combinationally):
- Reset: pulse rst asynchronously between edges -> all outputs 0 at once, cmd_ready=1 after release, later command reading R2 returns operand 0000.
- Load R0=0000, R1=1111; cmd op=00 srca=0 srcb=1 dst=2 -> mop_s0=0, mop_s1=0, mop_a=0000, mop_b=1111 for one cycle; rsp_valid after 2 edges with rsp_data=0000, rsp_dst=2.
- Same operands, ops 01/10/11 to dst 3 -> rsp_data 1111, 1111, 1111 in turn. Then R1 XOR R1 -> 0000; a later command reading R3 sees the last result.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid -> rsp_valid/rsp_data stable, cmd_ready=0, busy=1; a cmd_valid offered meanwhile is not taken. Accepted only after the response clears.
- Collision: ld_valid to addr 2 with data 0101 on the write-back edge of a command with dst=2 (result 1010) -> R2=1010. A load to srca on the accept edge -> operand uses the old value.
- Reset during ISSUE of a command with dst=1 -> R1=0, rsp_valid never asserts, mop_* return to 0 immediately.

Source files
------------

// File: rtl/logic_microop_sequencer.sv
// Initiator for the bitwise logic unit. It holds a 4-entry operand bank and runs AND/OR/XOR/NOT
// commands through the external unit. Each result is written back to the bank and returned on a handshake.
module logic_microop_sequencer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  input  logic [1:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_srca,
  input  logic [1:0]       cmd_srcb,
  input  logic [1:0]       cmd_dst,
  output logic [WIDTH-1:0] mop_a,
  output logic [WIDTH-1:0] mop_b,
  output logic             mop_s0,
  output logic             mop_s1,
  input  logic [WIDTH-1:0] mop_f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_dst,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [1:0]       dst_q;
  logic [WIDTH-1:0] bank [4];
  logic             accept;
  logic             wb_en;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && (state == IDLE);
  assign wb_en     = (state == ISSUE) && (settle_cnt == '0);

  // Write-back has priority over a direct load to the same entry on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        bank[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wb_en && (dst_q == 2'(i))) begin
          bank[i] <= mop_f;
        end else if (ld_valid && (ld_addr == 2'(i))) begin
          bank[i] <= ld_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      dst_q      <= '0;
      mop_a      <= '0;
      mop_b      <= '0;
      mop_s0     <= 1'b0;
      mop_s1     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_dst    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Operands come from the bank before any load landing on this same edge.
            mop_a      <= bank[cmd_srca];
            mop_b      <= bank[cmd_srcb];
            mop_s0     <= cmd_op[1];
            mop_s1     <= cmd_op[0];
            dst_q      <= cmd_dst;
            settle_cnt <= SETTLE_LOAD;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (settle_cnt == '0) begin
            rsp_data  <= mop_f;
            rsp_dst   <= dst_q;
            rsp_valid <= 1'b1;
            mop_a     <= '0;
            mop_b     <= '0;
            mop_s0    <= 1'b0;
            mop_s1    <= 1'b0;
            state     <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
